// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding and widths for the PLL lock supervisor.
package pll_sup_pkg;
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;
  localparam int RELOCK_W = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit double-flop synchronizer, async reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= 2'b00;
    else     {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset pulse, lock wait/qualify, sys_rst release and relock on loss-of-lock.
// Define PLL_SUP_LOL_FILTER_EN to require LOL_FILTER_CYCLES consecutive low samples for loss-of-lock in RUN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 4,
  parameter int LOL_FILTER_CYCLES   = 8
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                retry_req,
  output logic                pll_rst,
  output logic                sys_rst,
  output logic                lock_fail,
  output logic [RELOCK_W-1:0] relock_cnt,
  output state_t              state
);
  localparam int MAX_CNT = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES)
    ? ((RST_PULSE_CYCLES > STABLE_CYCLES) ? RST_PULSE_CYCLES : STABLE_CYCLES)
    : ((LOCK_TIMEOUT_CYCLES > STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : STABLE_CYCLES);
  localparam int CNT_W = $clog2(MAX_CNT + 1);
  localparam int RTW   = $clog2(MAX_RETRIES + 1);

  if (RST_PULSE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || STABLE_CYCLES < 1 ||
      MAX_RETRIES < 1 || LOL_FILTER_CYCLES < 1) begin : g_bad_param
    $error("pll_lock_supervisor: cycle parameters must be >= 1");
  end

  state_t           state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [RTW-1:0]   retry_cnt, retry_d;
  logic             lock_s, lol;

  sync_2ff u_sync (.clk(refclk), .rst(rst), .d(pll_locked), .q(lock_s));

`ifdef PLL_SUP_LOL_FILTER_EN
  localparam int FW = $clog2(LOL_FILTER_CYCLES + 1);
  logic [FW-1:0] flt;
  assign lol = !lock_s && flt == FW'(LOL_FILTER_CYCLES - 1);
  always_ff @(posedge refclk or posedge rst)
    if (rst) flt <= '0;
    else     flt <= (state == RUN && !lock_s && !lol) ? flt + FW'(1) : '0;
`else
  assign lol = !lock_s;
`endif

  always_comb begin
    state_d = state;
    retry_d = retry_cnt;
    unique case (state)
      PLL_RST:   if (cnt == CNT_W'(RST_PULSE_CYCLES - 1)) state_d = WAIT_LOCK;
      WAIT_LOCK:
        if (lock_s) state_d = STABLE;
        else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_d = retry_cnt + RTW'(1);
          state_d = (retry_cnt == RTW'(MAX_RETRIES - 1)) ? FAIL : PLL_RST;
        end
      STABLE:
        if (lock_s && cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = RUN;
          retry_d = '0;
        end
      RUN:       if (lol) state_d = PLL_RST;
      FAIL:
        if (retry_req) begin
          state_d = PLL_RST;
          retry_d = '0;
        end
      default:   state_d = PLL_RST;
    endcase
    // a low sample in STABLE restarts qualification without leaving the state
    cnt_d = (state_d != state || (state == STABLE && !lock_s) || state == RUN || state == FAIL)
      ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state      <= PLL_RST;
      cnt        <= '0;
      retry_cnt  <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      lock_fail  <= 1'b0;
      relock_cnt <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      retry_cnt  <= retry_d;
      pll_rst    <= state_d == PLL_RST || state_d == FAIL;
      sys_rst    <= state_d != RUN;
      lock_fail  <= state_d == FAIL;
      relock_cnt <= (state == RUN && lol && relock_cnt != '1) ? relock_cnt + RELOCK_W'(1) : relock_cnt;
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed checks of lock sequencing, retries, glitches, async reset and saturation.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;
  logic refclk = 1'b0, rst = 1'b1, pll_locked = 1'b0, retry_req = 1'b0;
  logic pll_rst, sys_rst, lock_fail;
  logic [7:0] relock_cnt;
  state_t state;
  int total = 0, bad = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32), .STABLE_CYCLES(8),
    .MAX_RETRIES(2), .LOL_FILTER_CYCLES(3)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .retry_req(retry_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .lock_fail(lock_fail),
    .relock_cnt(relock_cnt), .state(state)
  );

  always #5 refclk = ~refclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic relock_event();
    int i;
    pll_locked = 1'b0;
    for (i = 0; i < 20 && !sys_rst; i++) step(1);
    chk("lol_seen", sys_rst, 1);
    pll_locked = 1'b1;
    for (i = 0; i < 60 && state != RUN; i++) step(1);
    chk("relock_run", state, RUN);
  endtask

  initial begin
    step(2);
    chk("rst_state", state, PLL_RST);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_lock_fail", lock_fail, 0);
    chk("rst_relock", relock_cnt, 0);

    // case 1: normal lock, pll_locked rises 10 cycles after release
    rst = 1'b0;
    step(3);
    chk("c1_pulse_p3", pll_rst, 1);
    step(1);
    chk("c1_pulse_end", pll_rst, 0);
    chk("c1_wait", state, WAIT_LOCK);
    step(6);
    pll_locked = 1'b1;
    step(10);
    chk("c1_sysrst_p20", sys_rst, 1);
    chk("c1_stable", state, STABLE);
    step(1);
    chk("c1_sysrst_p21", sys_rst, 0);
    chk("c1_run", state, RUN);
    chk("c1_pll_rst", pll_rst, 0);

    // case 4: two-cycle glitch in RUN
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
`ifdef PLL_SUP_LOL_FILTER_EN
    step(1);
    chk("c4f_q3_sysrst", sys_rst, 0);
    step(4);
    chk("c4f_q7_run", state, RUN);
    chk("c4f_relock0", relock_cnt, 0);
    pll_locked = 1'b0;
    step(4);
    chk("c4f_r4_sysrst", sys_rst, 0);
    step(1);
    chk("c4f_r5_sysrst", sys_rst, 1);
    chk("c4f_r5_state", state, PLL_RST);
    chk("c4f_relock1", relock_cnt, 1);
    pll_locked = 1'b1;
    step(13);
    chk("c4f_r18_run", state, RUN);
`else
    chk("c4_q2_sysrst", sys_rst, 0);
    step(1);
    chk("c4_q3_sysrst", sys_rst, 1);
    chk("c4_q3_state", state, PLL_RST);
    chk("c4_q3_pll_rst", pll_rst, 1);
    chk("c4_relock1", relock_cnt, 1);
    step(3);
    chk("c4_q6_pll_rst", pll_rst, 1);
    step(1);
    chk("c4_q7_pll_rst", pll_rst, 0);
    step(9);
    chk("c4_q16_run", state, RUN);
    chk("c4_q16_sysrst", sys_rst, 0);
`endif

    // case 6: async reset between edges in RUN
    #2 rst = 1'b1;
    #1;
    chk("c6_state", state, PLL_RST);
    chk("c6_pll_rst", pll_rst, 1);
    chk("c6_sys_rst", sys_rst, 1);
    chk("c6_relock", relock_cnt, 0);

    // case 5: one-cycle glitch at stable count 5 (pll_locked already high)
    step(1);
    rst = 1'b0;
    step(12);
    chk("c5_p12_stable", state, STABLE);
    step(-2 + 2);
    chk("c5_p12_sysrst", sys_rst, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(10);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(2);
    chk("c5_p13_stable", state, STABLE);
    chk("c5_p13_pll_rst", pll_rst, 0);
    step(7);
    chk("c5_p20_sysrst", sys_rst, 1);
    chk("c5_p20_pll_rst", pll_rst, 0);
    step(1);
    chk("c5_p21_sysrst", sys_rst, 0);
    chk("c5_p21_run", state, RUN);

    // case 2: no lock -> two attempts then FAIL
    rst = 1'b1;
    pll_locked = 1'b0;
    step(1);
    rst = 1'b0;
    step(35);
    chk("c2_p35_wait", state, WAIT_LOCK);
    chk("c2_p35_pll_rst", pll_rst, 0);
    step(1);
    chk("c2_p36_pll_rst", pll_rst, 1);
    chk("c2_p36_state", state, PLL_RST);
    step(3);
    chk("c2_p39_pll_rst", pll_rst, 1);
    step(1);
    chk("c2_p40_pll_rst", pll_rst, 0);
    step(31);
    chk("c2_p71_wait", state, WAIT_LOCK);
    chk("c2_p71_fail", lock_fail, 0);
    step(1);
    chk("c2_p72_state", state, FAIL);
    chk("c2_p72_fail", lock_fail, 1);
    chk("c2_p72_pll_rst", pll_rst, 1);
    chk("c2_p72_sys_rst", sys_rst, 1);
    step(10);
    chk("c2_hold_fail", state, FAIL);
    chk("c2_hold_pll_rst", pll_rst, 1);

    // case 3: recovery from FAIL; retry_req in RUN is ignored
    retry_req = 1'b1;
    pll_locked = 1'b1;
    step(1);
    retry_req = 1'b0;
    chk("c3_f1_fail", lock_fail, 0);
    chk("c3_f1_state", state, PLL_RST);
    chk("c3_f1_pll_rst", pll_rst, 1);
    step(3);
    chk("c3_f4_pll_rst", pll_rst, 1);
    step(1);
    chk("c3_f5_pll_rst", pll_rst, 0);
    step(8);
    chk("c3_f13_sysrst", sys_rst, 1);
    step(1);
    chk("c3_f14_run", state, RUN);
    chk("c3_f14_sysrst", sys_rst, 0);
    retry_req = 1'b1;
    step(1);
    retry_req = 1'b0;
    step(3);
    chk("c3_retry_ign_state", state, RUN);
    chk("c3_retry_ign_pll", pll_rst, 0);
    chk("c3_retry_ign_sys", sys_rst, 0);

    // case 7: relock counter saturation
    relock_event();
    chk("c7_cnt1", relock_cnt, 1);
    for (int k = 1; k < 255; k++) relock_event();
    chk("c7_cnt255", relock_cnt, 255);
    for (int k = 0; k < 5; k++) relock_event();
    chk("c7_sat", relock_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
